// File: rtl/spi_flash_ctrl.sv
// Memory-mapped SPI mode-0 master for the j1 flash pins.
// Optional flash auto-read/stream sequencer: define SPI_FLASH_AUTOREAD_EN.
module spi_flash_ctrl #(
    parameter int          HALF   = 2,
    parameter logic [7:0]  RD_CMD = 8'h03
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sel,
    input  logic        i_io_rd,
    input  logic        i_io_wr,
    input  logic [1:0]  i_addr,
    input  logic [15:0] i_din,
    output logic [15:0] o_dout,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso,
    output logic        o_spi_cs_n,
    output logic        o_busy
);
    localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;
    state_t r_state, w_next;

    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx, r_rxsh, r_rx;
    logic          r_rx_valid, r_ovr, r_cs, r_cs_pend, r_cs_hold;
    logic          w_wr, w_rd, w_busy, w_half_end, w_done;
    logic          w_data_wr, w_ctrl_wr, w_data_rd;
    logic          w_launch, w_keep, w_kill_data, w_stream;
    logic [7:0]    w_launch_byte;
    logic [15:0]   w_ahi_rd, w_alo_rd;

    assign w_wr       = i_sel & i_io_wr;
    assign w_rd       = i_sel & i_io_rd;
    assign w_data_wr  = w_wr && (i_addr == 2'd0);
    assign w_ctrl_wr  = w_wr && (i_addr == 2'd1);
    assign w_data_rd  = w_rd && (i_addr == 2'd0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_half_end = (r_div == DW'(HALF - 1));
    assign w_done     = (r_state == S_HIGH) && w_half_end && (r_bit == 3'd7);

`ifdef SPI_FLASH_AUTOREAD_EN
    logic [7:0]  r_ahi;
    logic [15:0] r_alo;
    logic        r_stream, r_go;
    logic [2:0]  r_phase;
    logic        w_alo_start, w_kill;
    logic [7:0]  w_auto_tx;

    assign w_alo_start = w_wr && (i_addr == 2'd3) && !w_busy;
    assign w_kill      = r_stream && (w_data_wr || (w_ctrl_wr && !i_din[0]));
    assign w_kill_data = r_stream && w_data_wr;
    assign w_stream    = r_stream;
    assign w_keep      = !(r_stream && (r_phase != 3'd4));
    assign w_ahi_rd    = {8'd0, r_ahi};
    assign w_alo_rd    = r_alo;
    assign w_launch    = !w_busy && (w_data_wr || w_alo_start || r_go);

    always_comb begin
        w_auto_tx = 8'h00;
        unique case (r_phase)
            3'd1:    w_auto_tx = r_ahi;
            3'd2:    w_auto_tx = r_alo[15:8];
            3'd3:    w_auto_tx = r_alo[7:0];
            default: w_auto_tx = 8'h00;
        endcase
    end

    assign w_launch_byte = w_data_wr   ? i_din[7:0] :
                           w_alo_start ? RD_CMD     : w_auto_tx;

    // Header bytes chain automatically; the data byte after them is kept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ahi    <= '0;
            r_alo    <= '0;
            r_stream <= 1'b0;
            r_go     <= 1'b0;
            r_phase  <= '0;
        end else begin
            if (w_wr && (i_addr == 2'd2) && !w_busy)
                r_ahi <= i_din[7:0];
            if (w_alo_start) begin
                r_alo    <= i_din;
                r_stream <= 1'b1;
                r_phase  <= 3'd0;
            end
            if (w_launch)
                r_go <= 1'b0;
            if (w_done && r_stream && (r_phase != 3'd4)) begin
                r_phase <= r_phase + 3'd1;
                r_go    <= 1'b1;
            end
            if (w_data_rd && r_stream && (r_phase == 3'd4) && r_rx_valid)
                r_go <= 1'b1;
            if (w_kill) begin
                r_stream <= 1'b0;
                r_go     <= 1'b0;
            end
        end
    end
`else
    logic w_unused_din;
    assign w_unused_din  = ^{i_din[14:8], RD_CMD};
    assign w_kill_data   = 1'b0;
    assign w_stream      = 1'b0;
    assign w_keep        = 1'b1;
    assign w_ahi_rd      = '0;
    assign w_alo_rd      = '0;
    assign w_launch      = !w_busy && w_data_wr;
    assign w_launch_byte = i_din[7:0];
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_launch) w_next = S_LOW;
            S_LOW:   if (w_half_end) w_next = S_HIGH;
            S_HIGH:  if (w_half_end)
                         w_next = (r_bit == 3'd7) ? S_IDLE : S_LOW;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rxsh     <= '0;
            r_rx       <= '0;
            r_rx_valid <= 1'b0;
            r_ovr      <= 1'b0;
            r_cs       <= 1'b0;
            r_cs_pend  <= 1'b0;
            r_cs_hold  <= 1'b0;
        end else begin
            r_div <= (w_busy && !w_half_end) ? r_div + DW'(1) : '0;
            if (w_launch) begin
                r_tx  <= w_launch_byte;
                r_bit <= 3'd0;
            end
            if ((r_state == S_LOW) && w_half_end)
                r_rxsh <= {r_rxsh[6:0], i_spi_miso};
            if ((r_state == S_HIGH) && w_half_end && (r_bit != 3'd7)) begin
                r_tx  <= {r_tx[6:0], 1'b0};
                r_bit <= r_bit + 3'd1;
            end
            if (w_data_rd)
                r_rx_valid <= 1'b0;
            if (w_done && w_keep) begin
                r_rx       <= r_rxsh;
                r_rx_valid <= 1'b1;
            end
            if (w_ctrl_wr && i_din[15])
                r_ovr <= 1'b0;
            if (w_busy && w_data_wr)
                r_ovr <= 1'b1;
            // cs changes requested mid-byte take effect as the byte ends
            if (w_done) begin
                r_cs_hold <= 1'b0;
                if (w_ctrl_wr)      r_cs <= i_din[0];
                else if (r_cs_hold) r_cs <= r_cs_pend;
            end else if (w_ctrl_wr) begin
                if (w_busy) begin
                    r_cs_pend <= i_din[0];
                    r_cs_hold <= 1'b1;
                end else begin
                    r_cs <= i_din[0];
                end
            end
`ifdef SPI_FLASH_AUTOREAD_EN
            if (w_alo_start)
                r_cs <= 1'b1;
`endif
            if (w_kill_data) begin
                if (w_done) begin
                    r_cs <= 1'b0;
                end else begin
                    r_cs_pend <= 1'b0;
                    r_cs_hold <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_dout = '0;
        if (i_sel) begin
            unique case (i_addr)
                2'd0: o_dout = {8'd0, r_rx};
                2'd1: o_dout = {11'd0, w_stream, r_cs, r_ovr,
                                r_rx_valid, w_busy};
                2'd2: o_dout = w_ahi_rd;
                2'd3: o_dout = w_alo_rd;
            endcase
        end
    end

    assign o_spi_sck  = (r_state == S_HIGH);
    assign o_spi_mosi = r_tx[7];
    assign o_spi_cs_n = ~r_cs;
    assign o_busy     = w_busy;
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl (HALF=2); auto-read case needs
// SPI_FLASH_AUTOREAD_EN.
module tb_spi_flash_ctrl;
    logic        clk = 1'b0;
    logic        reset, sel, io_rd, io_wr;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        sck, mosi, miso, cs_n, busy;
    logic        loopback, flash, miso_const, fl_bit;
    logic [15:0] fl_data = 16'h5A6B;
    int          fl_base;
    int          n_rise = 0;
    logic [39:0] cap = '0;
    int          n_chk = 0;
    int          n_err = 0;

    spi_flash_ctrl #(.HALF(2), .RD_CMD(8'h03)) dut (
        .i_clk(clk), .i_reset(reset), .i_sel(sel),
        .i_io_rd(io_rd), .i_io_wr(io_wr), .i_addr(addr), .i_din(din),
        .o_dout(dout), .o_spi_sck(sck), .o_spi_mosi(mosi),
        .i_spi_miso(miso), .o_spi_cs_n(cs_n), .o_busy(busy)
    );

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : (flash ? fl_bit : miso_const);

    always @(posedge sck) begin
        n_rise = n_rise + 1;
        cap = {cap[38:0], mosi};
    end

    always @(negedge sck) begin
        if (flash && (n_rise - fl_base) >= 32 && (n_rise - fl_base) < 48)
            fl_bit = fl_data[47 - (n_rise - fl_base)];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        sel = 1'b1; io_wr = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        io_wr = 1'b0; sel = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        sel = 1'b1; io_rd = 1'b1; addr = a;
        #1 d = dout;
        @(posedge clk); #1;
        io_rd = 1'b0; sel = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [15:0] d);
        sel = 1'b1; addr = a;
        #1 d = dout;
        sel = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rxv(output int bad, output int k);
        bad = 0; k = 0;
        sel = 1'b1; addr = 2'd1;
        #1;
        while (!dout[1] && k < 4000) begin
            if (cs_n) bad = 1;
            @(posedge clk); #1;
            k++;
        end
        sel = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        int n, base, bad, k;
        reset = 1'b1; sel = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        addr = '0; din = '0; loopback = 1'b0; flash = 1'b0;
        miso_const = 1'b0; fl_base = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_sck", sck, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_mosi", mosi, 0);
        peek(2'd1, d); check("rst_ctrl", d, 16'h0000);

        bus_wr(2'd1, 16'h0001);
        check("t2_cs_n", cs_n, 0);
        loopback = 1'b1;
        base = n_rise;
        bus_wr(2'd0, 16'h00A5);
        wait_idle(n);
        check("t2_busy_cyc", n, 32);
        check("t2_rises", n_rise - base, 8);
        check("t2_mosi", cap[7:0], 8'hA5);
        peek(2'd1, d); check("t2_ctrl", d, 16'h000A);
        bus_rd(2'd0, d); check("t2_data", d, 16'h00A5);
        peek(2'd1, d); check("t2_rxv_clr", d, 16'h0008);

        loopback = 1'b0; miso_const = 1'b1;
        bus_wr(2'd0, 16'h0000);
        wait_idle(n);
        check("t3_busy_cyc", n, 32);
        check("t3_mosi", cap[7:0], 8'h00);
        check("t3_mosi_hold", mosi, 0);
        bus_rd(2'd0, d); check("t3_data", d, 16'h00FF);

        miso_const = 1'b0;
        base = n_rise;
        bus_wr(2'd0, 16'h0011);
        repeat (2) @(posedge clk);
        bus_wr(2'd0, 16'h0022);
        wait_idle(n);
        check("t4_idle", busy, 0);
        check("t4_rises", n_rise - base, 8);
        check("t4_mosi", cap[7:0], 8'h11);
        check("t4_mosi_hold", mosi, 1);
        peek(2'd1, d); check("t4_ctrl", d, 16'h000E);
        bus_wr(2'd1, 16'h8001);
        peek(2'd1, d); check("t4_ovr_clr", d, 16'h000A);
        bus_rd(2'd0, d); check("t4_data", d, 16'h0000);

        bus_wr(2'd0, 16'h005C);
        repeat (3) @(posedge clk); #1;
        bus_wr(2'd1, 16'h0000);
        bad = 0; k = 0;
        while (busy && k < 200) begin
            if (cs_n !== 1'b0) bad = 1;
            @(posedge clk); #1;
            k++;
        end
        check("t5_cs_held", bad, 0);
        check("t5_idle", busy, 0);
        check("t5_cs_n_fall", cs_n, 1);
        peek(2'd1, d); check("t5_ctrl", d, 16'h0002);

        @(negedge clk);
        sel = 1'b0; io_wr = 1'b1; addr = 2'd0; din = 16'h00FF;
        @(posedge clk); #1 io_wr = 1'b0;
        check("nosel_busy", busy, 0);
        bus_wr(2'd2, 16'h1234);
        peek(2'd2, d);
`ifdef SPI_FLASH_AUTOREAD_EN
        check("ahi_rd", d, 16'h0034);
`else
        check("reg2_zero", d, 16'h0000);
`endif

        bus_wr(2'd1, 16'h0001);
        bus_wr(2'd0, 16'h00C3);
        repeat (10) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("t1_cs_n", cs_n, 1);
        check("t1_sck", sck, 0);
        check("t1_busy", busy, 0);
        peek(2'd1, d); check("t1_ctrl", d, 16'h0000);
        peek(2'd0, d); check("t1_data", d, 16'h0000);
        @(negedge clk) reset = 1'b0;

`ifdef SPI_FLASH_AUTOREAD_EN
        flash = 1'b1; fl_bit = 1'b0;
        fl_base = n_rise;
        bus_wr(2'd2, 16'h0001);
        bus_wr(2'd3, 16'h2345);
        wait_rxv(bad, k);
        check("t6_cs_low1", bad, 0);
        check("t6_rises", n_rise - fl_base, 40);
        check("t6_mosi", cap, 40'h0301234500);
        bus_rd(2'd0, d); check("t6_byte0", d, 16'h005A);
        wait_rxv(bad, k);
        check("t6_cs_low2", bad, 0);
        bus_rd(2'd0, d); check("t6_byte1", d, 16'h006B);
        peek(2'd1, d); check("t6_stream", d[4], 1);
        peek(2'd2, d); check("t6_ahi", d, 16'h0001);
        peek(2'd3, d); check("t6_alo", d, 16'h2345);
        repeat (3) @(posedge clk); #1;
        bus_wr(2'd1, 16'h0000);
        wait_idle(n);
        check("t6_end_cs_n", cs_n, 1);
        peek(2'd1, d); check("t6_stream_off", d[4], 0);
        flash = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
